// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the ID-stage decoder.
//   pcsrc_e    - decoder PCSrc encoding (seq, branch, j/jal, jr/jalr, irq, exc)
//   RESET_VEC  - PC after reset (kernel mode)
//   IRQ_VEC    - interrupt entry
//   EXC_VEC    - illegal-op exception entry
//   NOP_INSTR  - instruction injected into IF/ID on a flush
//   pc_plus4() - sequential increment that never alters the mode bit
package cpu_pkg;

    typedef enum logic [2:0] {
        PCSRC_SEQ = 3'd0,
        PCSRC_BR  = 3'd1,
        PCSRC_JMP = 3'd2,
        PCSRC_JR  = 3'd3,
        PCSRC_IRQ = 3'd4,
        PCSRC_EXC = 3'd5
    } pcsrc_e;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Bit 31 is the kernel-mode flag: the low 31 bits wrap within the same mode.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_irq_latch.sv
// irq_latch: pending-interrupt flag for the fetch stage.
//   clk, rst   - core clock, asynchronous active-high reset
//   irq_i      - external interrupt level
//   accept_i   - PC is being redirected to the interrupt vector this cycle
//   pc31_i     - kernel-mode flag of the instruction in ID
//   irq_o      - pending interrupt, masked while in kernel mode
// Build option: IF_IRQ_SYNC_EN inserts a 2-flop synchronizer on irq_i.
module irq_latch (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic accept_i,
    input  logic pc31_i,
    output logic irq_o
);

    logic irq_s;
    logic pend_q;
    logic pend_d;

`ifdef IF_IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], irq_i};
        end
    end

    assign irq_s = sync_q[1];
`else
    assign irq_s = irq_i;
`endif

    // Acceptance beats a simultaneous set; a level still present re-sets next cycle.
    always_comb begin
        pend_d = pend_q | irq_s;
        if (accept_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign irq_o = pend_q & ~pc31_i;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
//   clk, reset        - core clock, asynchronous active-high reset
//   stall             - load-use hazard: hold PC and IF/ID
//   irq_in            - external interrupt level
//   id_pcsrc          - decoder PCSrc code (cpu_pkg::pcsrc_e)
//   id_jtarget        - instr[25:0] of the ID instruction
//   id_jr_addr        - forwarded rs value for jr/jalr
//   ex_br_taken       - EX branch resolved taken
//   ex_br_target      - EX branch target
//   imem_addr         - fetch address (= PC)
//   imem_data         - combinational instruction read
//   if_id_instr       - IF/ID instruction
//   if_id_pc4         - IF/ID PC+4
//   id_pc31           - kernel-mode flag of the ID instruction
//   irq_out           - pending interrupt to the decoder
// Build option: IF_IRQ_SYNC_EN (see irq_latch).
module if_stage #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        irq_in,
    input  logic [2:0]  id_pcsrc,
    input  logic [25:0] id_jtarget,
    input  logic [31:0] id_jr_addr,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        id_pc31,
    output logic        irq_out
);

    import cpu_pkg::*;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc4;
    logic [31:0] jmp_target;
    logic [31:0] jr_target;
    logic        irq_accept;

    assign pc4        = pc_plus4(pc_q);
    assign jmp_target = {pc4_q[31:28], id_jtarget, 2'b00};
    // User-mode code may not raise the mode bit through jr.
    assign jr_target  = {id_jr_addr[31] & pc4_q[31], id_jr_addr[30:0]};

    // Every redirect flushes IF/ID and records the pc4 of the squashed fetch,
    // which for an interrupt is the return address.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        irq_accept = 1'b0;
        if (ex_br_taken) begin
            pc_d    = ex_br_target;
            instr_d = NOP_INSTR;
            pc4_d   = pc4;
        end else if (!stall) begin
            instr_d = NOP_INSTR;
            pc4_d   = pc4;
            case (id_pcsrc)
                PCSRC_IRQ: begin
                    pc_d       = IRQ_VEC;
                    irq_accept = 1'b1;
                end
                PCSRC_EXC: pc_d = EXC_VEC;
                PCSRC_JMP: pc_d = jmp_target;
                PCSRC_JR:  pc_d = jr_target;
                default: begin
                    pc_d    = pc4;
                    instr_d = imem_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            instr_q <= NOP_INSTR;
            pc4_q   <= RESET_VEC;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    irq_latch u_irq_latch (
        .clk      (clk),
        .rst      (reset),
        .irq_i    (irq_in),
        .accept_i (irq_accept),
        .pc31_i   (pc4_q[31]),
        .irq_o    (irq_out)
    );

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign id_pc31     = pc4_q[31];

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Holds the PC and selects next-PC from the ID-stage PCSrc code and the EX-stage branch resolution.
- Drives instruction-memory address; registers the IF/ID pipeline latch.
- Owns the pending-interrupt latch that produces irq and PC31 for the ID-stage decoder.

Parameters:
- RESET_VEC, 32'h8000_0000, PC after reset (kernel mode).
- IRQ_VEC, 32'h8000_0004, interrupt entry.
- EXC_VEC, 32'h8000_0008, illegal-op exception entry.
- NOP_INSTR, 32'h0000_0000, instruction injected on flush.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-high reset
- stall  in  1  load-use hazard; hold PC and IF/ID
- irq_in  in  1  external interrupt level (timer/peripheral)
- id_pcsrc  in  3  decoder PCSrc: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 irq, 5 exc
- id_jtarget  in  26  instr[25:0] of ID instruction
- id_jr_addr  in  32  forwarded rs value in ID
- ex_br_taken  in  1  EX branch condition true (ALU result bit 0 with Branch)
- ex_br_target  in  32  EX branch target
- imem_addr  out  32  fetch address (= PC)
- imem_data  in  32  combinational instruction read
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4
- id_pc31  out  1  if_id_pc4[31], kernel-mode flag to decoder
- irq_out  out  1  pending interrupt to decoder

Behaviour:
- Async reset: PC=RESET_VEC; if_id_instr=NOP_INSTR; if_id_pc4=RESET_VEC; irq_pend=0. Hence id_pc31=1, irq_out=0.
- pc4 = {PC[31], PC[30:0]+31'd4}. Bit 31 never carries or changes by increment; wrap of the low 31 bits stays in the same mode.
- Jump target = {if_id_pc4[31:28], id_jtarget, 2'b00}.
- jr target = id_jr_addr, except user mode (if_id_pc4[31]=0) cannot set bit 31: next PC[31] = id_jr_addr[31] & if_id_pc4[31].
- Next-PC priority, highest first:
  1. ex_br_taken: PC=ex_br_target; IF/ID flushed to NOP. Applies even if stall=1; overrides everything.
  2. stall: PC and IF/ID hold; irq_pend still sets but does not clear.
  3. id_pcsrc=4: PC=IRQ_VEC; IF/ID flushed. if_id_pc4 loads current pc4, keeping a valid return address.
  4. id_pcsrc=5: PC=EXC_VEC; IF/ID flushed.
  5. id_pcsrc=2: jump target; IF/ID flushed.
  6. id_pcsrc=3: jr target; IF/ID flushed.
  7. Otherwise (0, or 1 while branch unresolved): PC=pc4; IF/ID loads imem_data, pc4.
- Latency: one cycle from imem_addr to if_id_instr. No branch delay slot; taken branch costs 2 bubbles, jump costs 1.
- Interrupt latch:
  - irq_pend sets on any cycle irq_in=1.
  - Clears on the cycle the PC is redirected by rule 3 (accepted).
  - irq_out = irq_pend & ~id_pc31. Masked in kernel mode; stays pending until return to user mode.
  - Set and clear in the same cycle: clear wins, but a new level re-sets next cycle.
- If rule 3 fires while IF/ID already holds a flushed NOP, the handler still enters. No interrupt is dropped.
- Reset mid-redirect: reset wins immediately and asynchronously.

Optional Feature:
- IF_IRQ_SYNC_EN defined: irq_in passes through a 2-flop synchronizer (reset 0) before irq_pend. irq_out latency from irq_in becomes 3 cycles.
- Undefined: irq_in samples directly. irq_out is asserted 1 cycle after irq_in rises (user mode).

Decomposition:
- Shared package cpu_pkg: PCSrc codes (PCSRC_SEQ..PCSRC_EXC), RESET_VEC/IRQ_VEC/EXC_VEC, NOP_INSTR. The decoder uses the same package.
- Sub-module irq_latch: optional synchronizer, pending flag, kernel mask. if_stage keeps PC mux and IF/ID register.

Test Plan:
- Reset release, imem returns 32'h2008_0005 -> imem_addr 0x8000_0000, then 0x8000_0004; if_id_instr=0x2008_0005, if_id_pc4=0x8000_0004.
- ex_br_taken=1, target 0x0000_0040, with stall=1 -> next imem_addr 0x40; if_id_instr=0 (flush overrides stall).
- PC=0x0000_0100, id_pcsrc=2, jtarget=26'h10 -> imem_addr 0x0000_0040; if_id_instr=0.
- User mode, id_pcsrc=3, id_jr_addr=0x8000_0010 -> PC=0x0000_0010 (bit 31 blocked). In kernel mode, the same stimulus -> PC=0x8000_0010.
- irq_in pulse 1 cycle at PC 0x0000_0200 -> irq_out=1 next cycle. With id_pcsrc=4, PC=0x8000_0004 and irq_out falls. A pulse in kernel mode -> irq_out=0 until PC31 returns to 0.
- stall=1 for 3 cycles with PC=0x0000_0020 -> imem_addr and IF/ID unchanged all 3 cycles; sequential fetch resumes at 0x24.
